// File: rtl/mem_arbiter_if.sv
// Bus bundle between cpu16 (fetch + data ports), the arbiter and the unified RAM.
// The arbiter takes the slave view; the cpu/RAM environment takes the master view.
interface mem_arbiter_if #(
    parameter int unsigned AWIDTH = 16,
    parameter int unsigned DWIDTH = 16
);
    logic [AWIDTH-1:0] ins_rd_addr;
    logic              ins_rd_req;
    logic [DWIDTH-1:0] ins_rd_data;
    logic              ins_rd_rdy;

    logic [AWIDTH-1:0] dat_rw_addr;
    logic [DWIDTH-1:0] dat_wr_data;
    logic              dat_rd_req;
    logic              dat_wr_req;
    logic [DWIDTH-1:0] dat_rd_data;
    logic              dat_rd_rdy;
    logic              dat_wr_rdy;

    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DWIDTH-1:0] mem_rdata;

    modport slave (
        input  ins_rd_addr, ins_rd_req,
        output ins_rd_data, ins_rd_rdy,
        input  dat_rw_addr, dat_wr_data, dat_rd_req, dat_wr_req,
        output dat_rd_data, dat_rd_rdy, dat_wr_rdy,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output ins_rd_addr, ins_rd_req,
        input  ins_rd_data, ins_rd_rdy,
        output dat_rw_addr, dat_wr_data, dat_rd_req, dat_wr_req,
        input  dat_rd_data, dat_rd_rdy, dat_wr_rdy,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the cpu16 fetch port
// and its data read/write port; one transaction in flight at a time.
module mem_arbiter #(
    parameter int unsigned AWIDTH  = 16,
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned MEM_LAT = 1
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus_io
);
    localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic              last_ins_q, last_ins_d;  // 1: previous grant went to the fetch port
    logic              gnt_ins_q, gnt_ins_d;
    logic              gnt_wr_q, gnt_wr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [DWIDTH-1:0] ins_data_q, ins_data_d;
    logic [DWIDTH-1:0] dat_data_q, dat_data_d;
    logic              ins_pend, dat_pend, pick_ins, pick_wr;

    assign ins_pend = bus_io.ins_rd_req;
    assign dat_pend = bus_io.dat_wr_req | bus_io.dat_rd_req;

    always_comb begin
        state_d     = state_q;
        last_ins_d  = last_ins_q;
        gnt_ins_d   = gnt_ins_q;
        gnt_wr_d    = gnt_wr_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        ins_data_d  = ins_data_q;
        dat_data_d  = dat_data_q;
        pick_ins    = 1'b0;
        pick_wr     = 1'b0;

        case (state_q)
            StIdle: begin
                if (ins_pend || dat_pend) begin
                    // Contention goes to whichever side was not served last.
                    pick_ins    = ins_pend && (!dat_pend || !last_ins_q);
                    pick_wr     = !pick_ins && bus_io.dat_wr_req;
                    gnt_ins_d   = pick_ins;
                    gnt_wr_d    = pick_wr;
                    last_ins_d  = pick_ins;
                    mem_addr_d  = pick_ins ? bus_io.ins_rd_addr : bus_io.dat_rw_addr;
                    mem_wdata_d = bus_io.dat_wr_data;
                    mem_we_d    = pick_wr;
                    mem_re_d    = !pick_wr;
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (gnt_wr_q) begin
                    state_d = StResp;
                end else begin
                    cnt_d   = LatInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    if (gnt_ins_q) begin
                        ins_data_d = bus_io.mem_rdata;
                    end else begin
                        dat_data_d = bus_io.mem_rdata;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            last_ins_q  <= 1'b0;
            gnt_ins_q   <= 1'b0;
            gnt_wr_q    <= 1'b0;
            cnt_q       <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            ins_data_q  <= '0;
            dat_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_ins_q  <= last_ins_d;
            gnt_ins_q   <= gnt_ins_d;
            gnt_wr_q    <= gnt_wr_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            ins_data_q  <= ins_data_d;
            dat_data_q  <= dat_data_d;
        end
    end

    assign bus_io.mem_addr    = mem_addr_q;
    assign bus_io.mem_wdata   = mem_wdata_q;
    assign bus_io.mem_re      = mem_re_q;
    assign bus_io.mem_we      = mem_we_q;
    assign bus_io.ins_rd_data = ins_data_q;
    assign bus_io.dat_rd_data = dat_data_q;
    assign bus_io.ins_rd_rdy  = (state_q == StResp) && gnt_ins_q;
    assign bus_io.dat_rd_rdy  = (state_q == StResp) && !gnt_ins_q && !gnt_wr_q;
    assign bus_io.dat_wr_rdy  = (state_q == StResp) && gnt_wr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance with MEM_LAT=1 driven through a completion
// queue, and one with MEM_LAT=3 for the long-latency read.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   re_cnt = 0;

    // kind: 0 fetch read, 1 data read, 2 data write; due < 0 means cycle not checked
    typedef struct {
        int          kind;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    mem_arbiter_if #(.AWIDTH(16), .DWIDTH(16)) bus1 ();
    mem_arbiter_if #(.AWIDTH(16), .DWIDTH(16)) bus3 ();

    mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .MEM_LAT(1)) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus1)
    );

    mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .MEM_LAT(3)) u_dut3 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM for the MEM_LAT=1 instance; idle cycles return noise.
    logic [15:0] ram1 [65536];
    logic [15:0] rdat1;
    always @(posedge clk) begin
        if (reset) begin
            ram1[16'h0010] <= 16'h1234;
            ram1[16'h0030] <= 16'h3333;
            ram1[16'h0040] <= 16'h4444;
        end else if (bus1.mem_we) begin
            ram1[bus1.mem_addr] <= bus1.mem_wdata;
        end
        rdat1 <= bus1.mem_re ? ram1[bus1.mem_addr] : 16'($urandom);
    end
    assign bus1.mem_rdata = rdat1;

    // RAM for the MEM_LAT=3 instance: three-stage read pipe, noise whenever not valid.
    logic [15:0] ram3 [65536];
    logic [15:0] d3 [3];
    logic [2:0]  v3;
    logic [15:0] g3;
    always @(posedge clk) begin
        if (reset) ram3[16'h0050] <= 16'h5A5A;
        d3[0] <= ram3[bus3.mem_addr];
        d3[1] <= d3[0];
        d3[2] <= d3[1];
        v3    <= {v3[1:0], bus3.mem_re};
        g3    <= 16'($urandom);
    end
    assign bus3.mem_rdata = v3[2] ? d3[2] : g3;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Completion monitor for the MEM_LAT=1 instance.
    int          mon_n;
    int          mon_kind;
    logic [15:0] mon_data;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (bus1.mem_re) re_cnt++;
        mon_n = int'(bus1.ins_rd_rdy) + int'(bus1.dat_rd_rdy) + int'(bus1.dat_wr_rdy);
        if (mon_n != 0) begin
            check_eq("single_rdy", mon_n, 1);
            mon_kind = bus1.ins_rd_rdy ? 0 : (bus1.dat_rd_rdy ? 1 : 2);
            mon_data = bus1.ins_rd_rdy ? bus1.ins_rd_data : bus1.dat_rd_data;
            if (exp_q.size() == 0) begin
                check_eq("rdy_expected", 0, 1);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("rdy_kind", mon_kind, mon_e.kind);
                if (mon_e.kind != 2) check_eq("rd_data", {16'h0, mon_data}, {16'h0, mon_e.data});
                if (mon_e.due >= 0) check_eq("rdy_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic push_exp(input int kind, input logic [15:0] data, input int due);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.due  = due;
        exp_q.push_back(e);
    endtask

    // Returns #1 after a posedge once at most n completions remain outstanding.
    task automatic wait_left(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() <= n) break;
        end
        if (exp_q.size() > n) begin
            check_eq("wait_timeout", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        int          c;
        int          got;
        int          re0;
        logic [15:0] rd;

        reset = 1'b1;
        bus1.ins_rd_addr = '0; bus1.ins_rd_req = 1'b0;
        bus1.dat_rw_addr = '0; bus1.dat_wr_data = '0;
        bus1.dat_rd_req  = 1'b0; bus1.dat_wr_req = 1'b0;
        bus3.ins_rd_addr = '0; bus3.ins_rd_req = 1'b0;
        bus3.dat_rw_addr = '0; bus3.dat_wr_data = '0;
        bus3.dat_rd_req  = 1'b0; bus3.dat_wr_req = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_addr", bus1.mem_addr, 0);
        check_eq("rst_mem_wdata", bus1.mem_wdata, 0);
        check_eq("rst_strobes", {bus1.mem_re, bus1.mem_we}, 0);
        check_eq("rst_rdys", {bus1.ins_rd_rdy, bus1.dat_rd_rdy, bus1.dat_wr_rdy}, 0);
        check_eq("rst_rd_data", {bus1.ins_rd_data, bus1.dat_rd_data}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Long-latency fetch; noise on mem_rdata before the valid cycle must be ignored.
        c = cyc;
        bus3.ins_rd_addr = 16'h0050;
        bus3.ins_rd_req  = 1'b1;
        got = -1;
        rd  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus3.ins_rd_rdy) begin
                got = cyc;
                rd  = bus3.ins_rd_data;
                break;
            end
        end
        check_eq("lat3_cycle", got, c + 5);
        check_eq("lat3_data", {16'h0, rd}, 32'h5A5A);
        @(posedge clk); #1;
        bus3.ins_rd_req = 1'b0;
        @(negedge clk);
        check_eq("lat3_rdy_pulse", bus3.ins_rd_rdy, 0);
        @(posedge clk); #1;

        // Fetch only.
        c   = cyc;
        re0 = re_cnt;
        bus1.ins_rd_addr = 16'h0010;
        bus1.ins_rd_req  = 1'b1;
        push_exp(0, 16'h1234, c + 3);
        wait_left(0, 20);
        bus1.ins_rd_req = 1'b0;
        check_eq("fetch_re_cycles", re_cnt - re0, 1);

        // Write then read back the same word.
        c = cyc;
        bus1.dat_rw_addr = 16'h0020;
        bus1.dat_wr_data = 16'hBEEF;
        bus1.dat_wr_req  = 1'b1;
        push_exp(2, 16'h0000, c + 2);
        wait_left(0, 20);
        bus1.dat_wr_req = 1'b0;
        c = cyc;
        bus1.dat_rd_req = 1'b1;
        push_exp(1, 16'hBEEF, c + 3);
        wait_left(0, 20);
        bus1.dat_rd_req = 1'b0;
        check_eq("ins_data_hold", bus1.ins_rd_data, 16'h1234);

        // Write and read together: the write wins, the read follows on the next grant.
        c = cyc;
        bus1.dat_rw_addr = 16'h0030;
        bus1.dat_wr_data = 16'hC0DE;
        bus1.dat_wr_req  = 1'b1;
        bus1.dat_rd_req  = 1'b1;
        push_exp(2, 16'h0000, c + 2);
        push_exp(1, 16'hC0DE, c + 6);
        wait_left(1, 20);
        bus1.dat_wr_req = 1'b0;
        wait_left(0, 20);
        bus1.dat_rd_req = 1'b0;

        // Both sides held: grants strictly alternate starting with the fetch.
        c = cyc;
        bus1.ins_rd_addr = 16'h0010;
        bus1.dat_rw_addr = 16'h0040;
        bus1.ins_rd_req  = 1'b1;
        bus1.dat_rd_req  = 1'b1;
        push_exp(0, 16'h1234, c + 3);
        push_exp(1, 16'h4444, c + 7);
        push_exp(0, 16'h1234, c + 11);
        push_exp(1, 16'h4444, c + 15);
        wait_left(0, 40);
        bus1.ins_rd_req = 1'b0;
        bus1.dat_rd_req = 1'b0;

        // Reset during the ACCESS cycle of a fetch.
        bus1.ins_rd_addr = 16'h0010;
        bus1.ins_rd_req  = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_in_access", bus1.mem_re, 1);
        reset           = 1'b1;
        bus1.ins_rd_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_strobes", {bus1.mem_re, bus1.mem_we}, 0);
        check_eq("abort_rdys", {bus1.ins_rd_rdy, bus1.dat_rd_rdy, bus1.dat_wr_rdy}, 0);
        repeat (6) @(posedge clk);
        #1;

        // Fresh contention after reset: fetch must win first.
        c = cyc;
        bus1.ins_rd_addr = 16'h0010;
        bus1.ins_rd_req  = 1'b1;
        bus1.dat_rw_addr = 16'h0060;
        bus1.dat_wr_data = 16'h6666;
        bus1.dat_wr_req  = 1'b1;
        push_exp(0, 16'h1234, c + 3);
        push_exp(2, 16'h0000, c + 6);
        wait_left(1, 20);
        bus1.ins_rd_req = 1'b0;
        wait_left(0, 20);
        bus1.dat_wr_req = 1'b0;
        c = cyc;
        bus1.dat_rd_req = 1'b1;
        push_exp(1, 16'h6666, c + 3);
        wait_left(0, 20);
        bus1.dat_rd_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
